// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed driver for common-anode 7-segment displays.
// It takes a packed digit vector and latches it on a load strobe into a shadow
// register. At the frame boundary it moves the shadow into the active register,
// so a frame never shows a mix of old and new digits. It scans one digit per
// slot and keeps all commons off for a short window at the start of each slot.
// It also provides leading-zero suppression and global blanking.
module fnd_scan_driver #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2,
  parameter int HEX_EN    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_load,
  input  logic                  i_blank,
  input  logic                  i_lzs_en,
  output logic [7:0]            o_font,
  output logic [N_DIGITS-1:0]   o_com,
  output logic                  o_frame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   shadow_val;
  logic [N_DIGITS-1:0]     shadow_dp;
  logic [4*N_DIGITS-1:0]   active_val;
  logic [N_DIGITS-1:0]     active_dp;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    upper_nonzero;
  logic                    suppress;
  logic                    in_guard;
  logic [N_DIGITS-1:0]     com_sel;

  assign tick     = (presc == PRESC_LAST);
  assign wrap     = tick && (idx == IDX_LAST);
  assign suppress = i_lzs_en && (idx != '0) && !upper_nonzero;
  assign in_guard = (BLANK_CYC != 0) && (presc < BLANK_END);

  // Segment pattern (g..a, active-low) for a digit code; codes 10-15 go dark when hex glyphs are disabled
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    if (HEX_EN == 0 && code > 4'd9) seg = 7'h7F;
    return seg;
  endfunction

  // Prescaler divides the clock into digit slots; the digit index steps once per slot and wraps after the last digit
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Loads land in the shadow copy (last one wins); only the frame wrap moves the shadow into the displayed copy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
    end else begin
      if (i_load) begin
        shadow_val <= i_value;
        shadow_dp  <= i_dp;
      end
      if (wrap) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
    end
  end

  // Select the current digit, decide whether it is a leading zero, and build the common pattern for this index
  always_comb begin
    cur_code      = '0;
    cur_dp        = 1'b0;
    upper_nonzero = 1'b0;
    com_sel       = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        cur_code   = active_val[4*k +: 4];
        cur_dp     = active_dp[k];
        com_sel[k] = 1'b0;
      end
      if (IW'(k) >= idx && active_val[4*k +: 4] != 4'h0) upper_nonzero = 1'b1;
    end
  end

  // Registered pin drive: dark during reset, global blank and the guard window, otherwise the current digit glyph
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_font  <= 8'hFF;
      o_com   <= '1;
      o_frame <= 1'b0;
    end else begin
      o_frame <= wrap;
      if (i_blank || in_guard) begin
        o_font <= 8'hFF;
        o_com  <= '1;
      end else begin
        o_font <= {~cur_dp, suppress ? 7'h7F : glyph(cur_code)};
        o_com  <= com_sel;
      end
    end
  end

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- Multi-digit, time-multiplexed 7-segment (FND) driver for common-anode displays with active-low segments and active-low digit commons.
- Accepts a packed BCD/hex vector, latches it on a load strobe and presents it tear-free at frame boundaries.
- Scans digits at a programmable rate, with inter-digit ghost blanking, leading-zero suppression, per-digit decimal point and global blanking.
- Sits between the counter/datapath logic and the board FND pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (1..8).
- SCAN_DIV, 100000, clock cycles per digit slot (>= 4).
- BLANK_CYC, 2, cycles at the start of each slot with all commons off (0 <= BLANK_CYC < SCAN_DIV).
- HEX_EN, 1, 1: codes A-F render as hex glyphs; 0: codes 10-15 render blank.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_value  in  4*N_DIGITS  packed digit codes; digit k = i_value[4k+3:4k], digit 0 = least significant, rightmost.
- i_dp  in  N_DIGITS  decimal point request per digit, 1 = lit.
- i_load  in  1  1-cycle strobe: sample i_value/i_dp into the shadow registers.
- i_blank  in  1  1 = all digits dark; scanning continues.
- i_lzs_en  in  1  1 = leading-zero suppression on.
- o_font  out  8  active-low segments, bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- o_com  out  N_DIGITS  active-low digit commons; at most one bit low at any time.
- o_frame  out  1  1-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - Reset values: o_font = 8'hFF, o_com = all ones, o_frame = 0, prescaler = 0, digit index = 0, shadow and active registers = 0.
  - Reset asserted mid-scan takes effect on the next edge; display goes dark immediately. A pending load is discarded.
- Glyph table, segment value with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - HEX_EN=1: A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - HEX_EN=0: codes 10-15 = FF.
  - A lit dp clears bit7.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps. Tick = (count == SCAN_DIV-1).
  - On tick, the digit index increments modulo N_DIGITS.
  - If the index wraps to 0, o_frame pulses in the same cycle the index becomes 0.
- Load and shadow registers:
  - i_load high on an edge copies i_value/i_dp into the shadow registers.
  - A later load before the frame boundary overwrites the earlier one (last wins).
  - Shadow is copied to the active registers on the tick that wraps the index to 0.
  - Load coinciding with the wrap tick: the new data goes to shadow only and becomes active at the following frame.
  - First frame after reset displays zeros.
- Digit slot timing, registered outputs valid 1 cycle after the counters:
  - Prescaler < BLANK_CYC: o_com = all ones, o_font = FF.
  - Otherwise: o_com[idx] = 0 and all other bits 1; o_font = glyph of the active digit idx.
- Leading-zero suppression (i_lzs_en=1):
  - Digit k is suppressed if its code is 0 and every active digit above k is also 0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows segments FF, but its dp is still honoured.
  - i_lzs_en and i_blank are live, not shadowed.
- i_blank = 1: o_font = FF and o_com = all ones from the next cycle; counters keep running.
- N_DIGITS=1: the index is always 0, o_frame pulses on every tick, and the commons toggle only for blanking.

Test Plan (N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, HEX_EN=1):
- Reset release, no load -> o_frame first pulses 32 cycles after reset; every slot shows o_font=C0 with o_com cycling 1110, 1101, 1011, 0111; each slot starts with 2 cycles of o_com=1111, o_font=FF.
- Load i_value=16'h1234, i_dp=4'b0100 mid-frame -> old value stays until the next o_frame; then digit 3='1'(F9), 2='2' with dp(24), 1='3'(B0), 0='4'(99).
- Load 16'h00A0 with i_lzs_en=1 -> digits 3 and 2 show FF with their commons still driven; digit 1=88; digit 0=C0. Load 16'h0000 -> only digit 0 shows C0.
- HEX_EN=0 build, load 16'hFEDC -> all digits FF; loads on consecutive cycles 16'h1111 then 16'h2222 -> only 2222 is displayed.
- Assert i_blank for 10 cycles -> o_com=1111 and o_font=FF throughout; o_frame cadence is unchanged.
- Assert i_reset mid-slot while showing 16'h1234 -> next cycle o_font=FF and o_com=1111; after release, zeros are displayed and the pending load is lost.
